pwm_audio_sequencer: RTL and testbench
======================================

# pwm_audio_sequencer

Sample scheduler that feeds the 12-bit `din` input of the PWM audio generator from a stream of signed 16-bit PCM samples. It buffers incoming samples in a small FIFO and primes it before playback. One sample is released per PWM period (4536 clocks of `clk_200mhz`, 44.1 kHz), with digital attenuation and signed-to-offset-binary conversion. It sits between the audio decoder (valid/ready producer) and the PWM generator, and reports underruns to software.

## Interface
- `PERIOD`, 4536: clocks per sample; must equal the PWM generator period.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `PRIME_LEVEL`, 8: FIFO occupancy required before playback starts; 1..DEPTH.

Ports:
- `clk_200mhz`  in  1  system clock, 200 MHz.
- `rst`  in  1  reset; asynchronous and active-high.
- `enable`  in  1  playback enable; level-sensitive.
- `volume`  in  3  attenuation; right-shift of the signed sample by 0..7 (0 = full scale).
- `s_data`  in  16  signed two's-complement PCM sample.
- `s_valid`  in  1  producer has a sample on `s_data`.
- `s_ready`  out  1  block accepts `s_data` this cycle.
- `pwm_din`  out  12  sample to the PWM generator `din`; registered.
- `sample_tick`  out  1  one-cycle pulse at each period boundary while playing.
- `playing`  out  1  high in state PLAY.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `underrun_cnt`  out  16  saturating count of ticks that found the FIFO empty.

## Operation
- **States.** IDLE, PRIME, PLAY.
  - IDLE → PRIME when `enable`=1.
  - PRIME → PLAY when `fifo_level` ≥ `PRIME_LEVEL`.
  - Any state → IDLE on the cycle after `enable`=0 is sampled.
- **IDLE.**
  - FIFO is flushed (level forced to 0).
  - Period counter is held at 0.
  - `pwm_din`=0x800 and `s_ready`=0.
  - `underrun_cnt` holds its value; only `rst` clears it.
- **PRIME.**
  - `s_ready` = !full.
  - Counter is held at 0.
  - `pwm_din` holds 0x800.
- **PLAY.**
  - `s_ready` = !full.
  - Counter counts 0..PERIOD-1 and wraps to 0.
  - `sample_tick` is high on the cycle where counter = PERIOD-1.
- **Tick with FIFO non-empty.** Pop the head entry; `pwm_din` updates on the next edge.
- **Tick with FIFO empty.** `pwm_din` is set to 0x800, `underrun_cnt` increments (saturating at 0xFFFF), and the block stays in PLAY. A refill does not re-prime.
- **Handshake.**
  - A push occurs on a rising edge where `s_valid` && `s_ready`.
  - `s_data` must be held by the producer until it is accepted.
  - `s_ready` is a registered function of the current level; it does not depend on `s_valid`.
- **Simultaneous push and pop.** Both take effect and the level is unchanged. A pop in the same cycle does not raise `s_ready` when full; the freed slot is visible the next cycle.
- **Conversion.** Applied combinationally to the popped entry, then registered into `pwm_din`:
  - a = s_data >>> volume (arithmetic shift, 16-bit).
  - u = {~a[15], a[14:0]}.
  - pwm_din = u[15:4].
  - Examples: 0x0000 → 0x800, 0x7FFF → 0xFFF, 0x8000 → 0x000.
- **FIFO pointers.** Wrap modulo DEPTH; the level is tracked with one extra bit so full and empty are distinguishable.

## Timing
- **Reset values** (asynchronous `rst`=1):
  - state=IDLE, counter=0, FIFO empty.
  - `pwm_din`=0x800.
  - `s_ready`=0, `sample_tick`=0, `playing`=0.
  - `fifo_level`=0, `underrun_cnt`=0.
- **Reset mid-operation.** Asserting `rst` during PLAY applies the reset values immediately, without waiting for a clock edge. After deassertion the block starts from IDLE.
- **PRIME → PLAY.**
  - The transition happens on the edge after the level reaches `PRIME_LEVEL`.
  - `playing` rises on that edge.
  - The counter is 0 on the first PLAY cycle.
  - The first `sample_tick` occurs PERIOD-1 cycles later (the PERIOD-th PLAY cycle).
- **Tick-to-output latency.** `pwm_din` changes exactly 1 cycle after the `sample_tick` cycle. Consecutive updates are exactly PERIOD cycles apart.
- **`enable` deassertion.**
  - Takes effect on the next edge: state=IDLE, `s_ready`=0, `playing`=0, `pwm_din`=0x800.
  - FIFO contents are discarded.
  - A tick landing on that same cycle still pops and updates `pwm_din`; the IDLE value of 0x800 overrides it on the following edge.
- **Throughput.** Push throughput is 1 sample per clock while not full.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-PLAY → all outputs return to reset values before the next clock edge; after release the block stays in IDLE until `enable`=1.
- **Prime and play.** `enable`=1; push 8 samples (0x0000, 0x7FFF, 0x8000, 0x4000, …) back-to-back with `volume`=0 → PLAY entered after the 8th push. The first `sample_tick` arrives PERIOD cycles into PLAY. `pwm_din` sequence is 0x800, 0xFFF, 0x000, 0xC00, each held exactly 4536 cycles.
- **Attenuation.** `volume`=3 with sample 0x7FFF → `pwm_din`=0x8FF; with sample 0x8000 → `pwm_din`=0x700.
- **Full FIFO.** Hold `s_valid`=1 continuously in PRIME/PLAY → `s_ready` drops when `fifo_level`=16 and no sample is lost. At a tick, the pop takes the level to 15 and `s_ready` reasserts on the next cycle.
- **Underrun.** Stop pushing in PLAY and let the FIFO drain → each empty tick sets `pwm_din`=0x800 and increments `underrun_cnt` (3 empty ticks → 3). Resuming pushes makes the next tick output the new sample without re-priming.
- **Disable mid-play.** Drop `enable` with 5 entries queued → the next edge gives IDLE, `fifo_level`=0, `pwm_din`=0x800, `s_ready`=0. Re-enabling requires a fresh prime of 8 samples.

Source files
------------

// File: rtl/pwm_audio_sequencer.sv
// Sample scheduler for the PWM audio generator: buffers signed PCM samples in a
// small FIFO, primes it, then releases one attenuated offset-binary sample per period.
module pwm_audio_sequencer #(
  parameter int PERIOD      = 4536,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                     clk_200mhz,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2:0]               volume,
  input  logic [15:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [11:0]              pwm_din,
  output logic                     sample_tick,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic                s_ready_q, s_ready_d;
  logic [11:0]         pwm_din_q, pwm_din_d;
  logic [15:0]         underrun_q, underrun_d;
  logic [15:0]         mem_q [DEPTH];

  logic                tick, empty, push, pop;
  logic [15:0]         head;
  logic signed [15:0]  shifted;
  logic [15:0]         offset_bin;

  always_comb begin
    tick       = (state_q == PLAY) && (cnt_q == CW'(PERIOD - 1));
    empty      = (level_q == '0);
    push       = s_valid && s_ready_q;
    pop        = tick && !empty;
    head       = mem_q[rd_ptr_q];
    shifted    = $signed(head) >>> volume;
    offset_bin = {~shifted[15], shifted[14:0]};

    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (level_q >= (AW + 1)'(PRIME_LEVEL)) state_d = PLAY;
        default: state_d = state_q;
      endcase
    end

    cnt_d = '0;
    if (state_q == PLAY && enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + (AW + 1)'(1);
    else if (!push && pop) level_d = level_q - (AW + 1)'(1);
    // Leaving for IDLE discards whatever is queued, including a same-cycle push.
    if (state_d == IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    s_ready_d = (state_d != IDLE) && (level_d != (AW + 1)'(DEPTH));

    // A tick on the disabling cycle still pops; the IDLE value follows one edge later.
    pwm_din_d = pwm_din_q;
    if (tick)                  pwm_din_d = pop ? 12'(offset_bin >> 4) : 12'h800;
    else if (state_d == IDLE)  pwm_din_d = 12'h800;

    underrun_d = underrun_q;
    if (tick && empty && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk_200mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s_ready_q  <= 1'b0;
      pwm_din_q  <= 12'h800;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      s_ready_q  <= s_ready_d;
      pwm_din_q  <= pwm_din_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk_200mhz) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign s_ready      = s_ready_q;
  assign pwm_din      = pwm_din_q;
  assign sample_tick  = tick;
  assign playing      = (state_q == PLAY);
  assign fifo_level   = level_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_pwm_audio_sequencer.sv
// Directed bench for pwm_audio_sequencer: conversion table plus hand-written
// sequences for priming, full FIFO, underrun, disable and asynchronous reset.
`timescale 1ns/1ps
module tb_pwm_audio_sequencer;
  localparam int P     = 64;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  volume = 3'd0;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] pwm_din;
  logic        sample_tick;
  logic        playing;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_cnt;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int prev_tick = 0;
  int play_cyc = 0;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  vol;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [12];

  pwm_audio_sequencer #(.PERIOD(P), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clk_200mhz   (clk),
    .rst          (rst),
    .enable       (enable),
    .volume       (volume),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .pwm_din      (pwm_din),
    .sample_tick  (sample_tick),
    .playing      (playing),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2 * P; c++) begin
      if (sample_tick) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_vec++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: got no sample_tick expected one within %0d cycles", name, 2 * P);
    end
    prev_tick = tick_cyc;
    tick_cyc  = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] prev_exp;
    int idx;
    bit acc;

    tbl[0]  = '{16'h0000, 3'd0, 12'h800};
    tbl[1]  = '{16'h7FFF, 3'd0, 12'hFFF};
    tbl[2]  = '{16'h8000, 3'd0, 12'h000};
    tbl[3]  = '{16'h4000, 3'd0, 12'hC00};
    tbl[4]  = '{16'h7FFF, 3'd3, 12'h8FF};
    tbl[5]  = '{16'h8000, 3'd3, 12'h700};
    tbl[6]  = '{16'h1234, 3'd0, 12'h923};
    tbl[7]  = '{16'hFFFF, 3'd0, 12'h7FF};
    tbl[8]  = '{16'h7FFF, 3'd7, 12'h80F};
    tbl[9]  = '{16'h8000, 3'd7, 12'h7F0};
    tbl[10] = '{16'hC000, 3'd1, 12'h600};
    tbl[11] = '{16'h0010, 3'd0, 12'h801};

    // Reset values
    step(3);
    rst = 1'b0;
    step(2);
    check("rst_pwm_din", 32'(pwm_din), 32'h800);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_tick", 32'(sample_tick), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_underrun", 32'(underrun_cnt), 0);

    // Prime with the whole table, back to back
    enable = 1'b1;
    step();
    check("prime_s_ready", 32'(s_ready), 1);
    check("prime_playing", 32'(playing), 0);
    for (int k = 0; k < 12; k++) begin
      s_valid = 1'b1;
      s_data  = tbl[k].data;
      step();
      check("prime_level", 32'(fifo_level), 32'(k + 1));
      check("prime_play_edge", 32'(playing), 32'(k >= PRIME));
      if (k == PRIME) play_cyc = cyc;
    end
    s_valid = 1'b0;

    // Table: one pop per tick, held exactly P cycles
    prev_exp = 12'h800;
    for (int i = 0; i < 12; i++) begin
      volume = tbl[i].vol;
      wait_tick("tbl_tick");
      if (i == 0) check("first_tick_delay", 32'(tick_cyc - play_cyc), 32'(P - 1));
      else        check("tick_interval", 32'(tick_cyc - prev_tick), 32'(P));
      check("tbl_hold", 32'(pwm_din), 32'(prev_exp));
      step();
      check("tbl_pwm_din", 32'(pwm_din), 32'(tbl[i].exp));
      $display("vec %0d data %h vol %0d pwm_din %h", i, tbl[i].data, tbl[i].vol, pwm_din);
      prev_exp = tbl[i].exp;
    end

    // Underrun: three empty ticks
    volume = 3'd0;
    for (int u = 1; u <= 3; u++) begin
      wait_tick("under_tick");
      check("under_interval", 32'(tick_cyc - prev_tick), 32'(P));
      check("under_level", 32'(fifo_level), 0);
      step();
      check("under_pwm_din", 32'(pwm_din), 32'h800);
      check("under_cnt", 32'(underrun_cnt), 32'(u));
      check("under_playing", 32'(playing), 1);
    end

    // Refill plays without re-priming
    s_valid = 1'b1;
    s_data  = 16'h7FFF;
    step();
    s_valid = 1'b0;
    check("refill_level", 32'(fifo_level), 1);
    wait_tick("refill_tick");
    step();
    check("refill_pwm_din", 32'(pwm_din), 32'hFFF);
    check("refill_under", 32'(underrun_cnt), 3);

    // Full FIFO with s_valid held
    idx = 1;
    s_valid = 1'b1;
    s_data  = 16'(idx << 4);
    for (int c = 0; c < 40; c++) begin
      acc = s_ready;
      step();
      if (acc) begin
        idx++;
        s_data = 16'(idx << 4);
      end
      if (fifo_level == 5'd16) break;
    end
    check("full_level", 32'(fifo_level), 16);
    check("full_s_ready", 32'(s_ready), 0);
    check("full_pushes", 32'(idx - 1), 16);
    wait_tick("full_tick");
    check("full_tick_level", 32'(fifo_level), 16);
    check("full_tick_ready", 32'(s_ready), 0);
    step();
    check("full_pop_level", 32'(fifo_level), 15);
    check("full_pop_ready", 32'(s_ready), 1);
    check("full_pop_pwm", 32'(pwm_din), 32'h801);
    step();
    check("full_refill_level", 32'(fifo_level), 16);
    check("full_refill_ready", 32'(s_ready), 0);
    s_valid = 1'b0;

    // Drain to 5 entries, checking order (no sample lost)
    for (int e = 2; e <= 12; e++) begin
      wait_tick("drain_tick");
      step();
      check("drain_pwm", 32'(pwm_din), 32'(12'h800 + e));
      check("drain_level", 32'(fifo_level), 32'(17 - e));
    end

    // Disable with 5 queued
    enable = 1'b0;
    step();
    check("dis_playing", 32'(playing), 0);
    check("dis_level", 32'(fifo_level), 0);
    check("dis_pwm", 32'(pwm_din), 32'h800);
    check("dis_s_ready", 32'(s_ready), 0);
    check("dis_under", 32'(underrun_cnt), 3);

    // Re-enable needs a fresh prime
    enable = 1'b1;
    step();
    s_valid = 1'b1;
    for (int k = 0; k < PRIME - 1; k++) begin
      s_data = 16'(16'h0100 * k);
      step();
    end
    s_valid = 1'b0;
    check("reprime_level", 32'(fifo_level), 32'(PRIME - 1));
    step(3);
    check("reprime_wait", 32'(playing), 0);
    s_valid = 1'b1;
    s_data  = 16'h2222;
    step();
    s_valid = 1'b0;
    check("reprime_full", 32'(fifo_level), 32'(PRIME));
    check("reprime_not_yet", 32'(playing), 0);
    step();
    check("reprime_play", 32'(playing), 1);

    // Asynchronous reset mid-PLAY
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    check("arst_playing", 32'(playing), 0);
    check("arst_s_ready", 32'(s_ready), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_pwm", 32'(pwm_din), 32'h800);
    check("arst_under", 32'(underrun_cnt), 0);
    check("arst_tick", 32'(sample_tick), 0);
    step(2);
    rst = 1'b0;
    step(3);
    check("post_rst_idle", 32'(playing), 0);
    check("post_rst_ready", 32'(s_ready), 0);
    enable = 1'b1;
    step();
    check("post_rst_prime", 32'(s_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
